// File: rtl/scd_pkg.sv
// -----------------------------------------------------------------------------
// scd_pkg -- shared CRAM field definitions for the shift-count / exponent
// datapath (SCD).
//
// Contents:
//   scada_sel_e  SCAD A operand source
//   scadb_sel_e  SCAD B operand source
//   scad_op_e    SCAD function
//   sc_sel_e     SC register action
//   magic_sext   sign-extend the 9-bit CRAM magic field to SCAD width
//   ar_exponent  extract the exponent of a floating AR as a 10-bit signed value
//
// Bit numbering follows the PDP-10 convention throughout: bit 0 is the MSB.
// -----------------------------------------------------------------------------
package scd_pkg;

  localparam int SCAD_W  = 10;
  localparam int MAGIC_W = 9;

  // Threshold for the "shift count is at least one full word" decode.
  localparam logic [0:SCAD_W-1] SC_WORD_BITS = 10'd36;

  typedef enum logic [1:0] {
    SCADA_FE     = 2'b00,
    SCADA_AR_POS = 2'b01,
    SCADA_AR_EXP = 2'b10,
    SCADA_MAGIC  = 2'b11
  } scada_sel_e;

  typedef enum logic [1:0] {
    SCADB_SC      = 2'b00,
    SCADB_AR_SIZE = 2'b01,
    SCADB_AR_HI   = 2'b10,
    SCADB_MAGIC   = 2'b11
  } scadb_sel_e;

  typedef enum logic [2:0] {
    SCAD_A   = 3'b000,
    SCAD_ADD = 3'b001,
    SCAD_SUB = 3'b010,
    SCAD_INC = 3'b011,
    SCAD_DEC = 3'b100,
    SCAD_OR  = 3'b101,
    SCAD_AND = 3'b110,
    SCAD_B   = 3'b111
  } scad_op_e;

  typedef enum logic [1:0] {
    SC_HOLD      = 2'b00,
    SC_LOAD_SCAD = 2'b01,
    SC_COUNT     = 2'b10,
    SC_LOAD_AR   = 2'b11
  } sc_sel_e;

  function automatic logic [0:SCAD_W-1] magic_sext(input logic [0:MAGIC_W-1] magic);
    return {magic[0], magic};
  endfunction

  // A negative floating AR holds its exponent in ones-complement form, so the
  // field is inverted under the sign before being sign-extended.
  function automatic logic [0:SCAD_W-1] ar_exponent(input logic [0:8] ar_hi);
    return {ar_hi[0], ar_hi[0], ar_hi[1:8] ^ {8{ar_hi[0]}}};
  endfunction

endpackage

// File: rtl/scad_alu.sv
// -----------------------------------------------------------------------------
// scad_alu -- 10-bit shift-count adder. Purely combinational; all arithmetic
// is two's complement modulo 1024 with the carry out discarded.
//
// Ports:
//   a_i       in  10  A operand
//   b_i       in  10  B operand
//   op_i      in  3   SCAD function (scad_op_e)
//   result_o  out 10  SCAD result
// -----------------------------------------------------------------------------
module scad_alu
  import scd_pkg::*;
(
  input  logic [SCAD_W-1:0] a_i,
  input  logic [SCAD_W-1:0] b_i,
  input  scad_op_e          op_i,
  output logic [SCAD_W-1:0] result_o
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // result_o unassigned, which would infer a latch.
    result_o = a_i;
    case (op_i)
      SCAD_A:   result_o = a_i;
      SCAD_ADD: result_o = a_i + b_i;
      SCAD_SUB: result_o = a_i - b_i;
      SCAD_INC: result_o = a_i + 10'd1;
      SCAD_DEC: result_o = a_i - 10'd1;
      SCAD_OR:  result_o = a_i | b_i;
      SCAD_AND: result_o = a_i & b_i;
      SCAD_B:   result_o = b_i;
      default:  result_o = a_i;
    endcase
  end

endmodule

// File: rtl/scd.sv
// -----------------------------------------------------------------------------
// scd -- shift count / floating exponent datapath.
//
// Holds the shift counter SC and floating exponent FE, drives the SCAD adder
// from CRAM-selected operands, and feeds the EDP ARL mux through ARMM.
//
// Ports:
//   eboxClk        in  1   clock, rising edge
//   eboxReset      in  1   asynchronous active-high reset
//   SCADA_SEL      in  2   SCAD A source (scada_sel_e)
//   SCADB_SEL      in  2   SCAD B source (scadb_sel_e)
//   SCAD_OP        in  3   SCAD function (scad_op_e)
//   SC_SEL         in  2   SC action (sc_sel_e)
//   FE_LOAD        in  1   load FE from SCAD
//   ARMM_SEL       in  1   0: MAGIC / VMA section, 1: SCAD / zero
//   MAGIC          in  9   CRAM magic field
//   EDP_AR         in  36  AR from EDP
//   VMA_section    in  5   VMA section, bits 13:17
//   SCD_SC         out 10  shift count register
//   SCD_FE         out 10  floating exponent register
//   SCD_SCAD       out 10  combinational SCAD result
//   SCD_ARMMupper  out 9   ARL mux bits 0:8
//   SCD_ARMMlower  out 5   ARL mux bits 13:17
//   SCD_SCneg      out 1   SC negative
//   SCD_SCge36     out 1   SC non-negative and >= 36
//   SCD_loopDone   out 1   one-cycle pulse after counting through zero
// -----------------------------------------------------------------------------
module scd
  import scd_pkg::*;
(
  input  logic                eboxClk,
  input  logic                eboxReset,
  input  logic [1:0]          SCADA_SEL,
  input  logic [1:0]          SCADB_SEL,
  input  logic [2:0]          SCAD_OP,
  input  logic [1:0]          SC_SEL,
  input  logic                FE_LOAD,
  input  logic                ARMM_SEL,
  input  logic [0:MAGIC_W-1]  MAGIC,
  input  logic [0:35]         EDP_AR,
  input  logic [13:17]        VMA_section,
  output logic [0:SCAD_W-1]   SCD_SC,
  output logic [0:SCAD_W-1]   SCD_FE,
  output logic [0:SCAD_W-1]   SCD_SCAD,
  output logic [0:8]          SCD_ARMMupper,
  output logic [13:17]        SCD_ARMMlower,
  output logic                SCD_SCneg,
  output logic                SCD_SCge36,
  output logic                SCD_loopDone
);

  scada_sel_e a_sel;
  scadb_sel_e b_sel;
  scad_op_e   scad_op;
  sc_sel_e    sc_sel;

  assign a_sel   = scada_sel_e'(SCADA_SEL);
  assign b_sel   = scadb_sel_e'(SCADB_SEL);
  assign scad_op = scad_op_e'(SCAD_OP);
  assign sc_sel  = sc_sel_e'(SC_SEL);

  logic [0:SCAD_W-1] sc_q, sc_d;
  logic [0:SCAD_W-1] fe_q, fe_d;
  logic              loop_done_q, loop_done_d;

  logic [0:SCAD_W-1] scad_a, scad_b, scad;

  // AR bits 12:17 and 19:26 are not consumed by this block.
  logic unused_ar;
  assign unused_ar = ^{EDP_AR[12:17], EDP_AR[19:26]};

  // ---------------------------------------------------------------------------
  // Operand selection
  // ---------------------------------------------------------------------------
  always_comb begin
    scad_a = fe_q;
    case (a_sel)
      SCADA_FE:     scad_a = fe_q;
      SCADA_AR_POS: scad_a = {4'b0, EDP_AR[0:5]};
      SCADA_AR_EXP: scad_a = ar_exponent(EDP_AR[0:8]);
      SCADA_MAGIC:  scad_a = magic_sext(MAGIC);
      default:      scad_a = fe_q;
    endcase
  end

  always_comb begin
    scad_b = sc_q;
    case (b_sel)
      SCADB_SC:      scad_b = sc_q;
      SCADB_AR_SIZE: scad_b = {4'b0, EDP_AR[6:11]};
      SCADB_AR_HI:   scad_b = {1'b0, EDP_AR[0:8]};
      SCADB_MAGIC:   scad_b = magic_sext(MAGIC);
      default:       scad_b = sc_q;
    endcase
  end

  scad_alu u_scad_alu (
    .a_i      (scad_a),
    .b_i      (scad_b),
    .op_i     (scad_op),
    .result_o (scad)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sc_d = sc_q;
    case (sc_sel)
      SC_HOLD:      sc_d = sc_q;
      SC_LOAD_SCAD: sc_d = scad;
      SC_COUNT:     sc_d = sc_q - 10'd1;    // wraps 0000 -> 1777
      SC_LOAD_AR:   sc_d = {EDP_AR[18], EDP_AR[27:35]};
      default:      sc_d = sc_q;
    endcase
  end

  // FE and SC load independently, so both take the same SCAD value when
  // FE_LOAD and SC_SEL=load-SCAD coincide.
  assign fe_d        = FE_LOAD ? scad : fe_q;
  assign loop_done_d = (sc_sel == SC_COUNT) && (sc_q == '0);

  always_ff @(posedge eboxClk or posedge eboxReset) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    if (eboxReset) begin
      sc_q        <= '0;
      fe_q        <= '0;
      loop_done_q <= 1'b0;
    end else begin
      sc_q        <= sc_d;
      fe_q        <= fe_d;
      loop_done_q <= loop_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign SCD_SC       = sc_q;
  assign SCD_FE       = fe_q;
  assign SCD_SCAD     = scad;
  assign SCD_loopDone = loop_done_q;

  assign SCD_SCneg  = sc_q[0];
  assign SCD_SCge36 = !sc_q[0] && (sc_q >= SC_WORD_BITS);

  // Combinational so the EDP can capture ARMM in the same cycle.
  assign SCD_ARMMupper = ARMM_SEL ? scad[1:9] : MAGIC;
  assign SCD_ARMMlower = ARMM_SEL ? 5'b0      : VMA_section;

endmodule

// File: doc/scd.md
SCD -- requirements
Module: scd

Interface
REQ-001 eboxClk  in  1  EBOX clock; all state changes on its rising edge.
REQ-002 eboxReset  in  1  asynchronous, active-high reset.
REQ-003 SCADA_SEL  in  2  SCAD A source: 00 FE, 01 AR position, 10 AR exponent, 11 MAGIC.
REQ-004 SCADB_SEL  in  2  SCAD B source: 00 SC, 01 AR size, 10 AR[0:8] zero-extended, 11 MAGIC.
REQ-005 SCAD_OP  in  3  SCAD function: 000 A, 001 A+B, 010 A-B, 011 A+1, 100 A-1, 101 A|B, 110 A&B, 111 B.
REQ-006 SC_SEL  in  2  SC action: 00 hold, 01 load SCAD, 10 count down, 11 load {AR[18], AR[27:35]}.
REQ-007 FE_LOAD  in  1  load FE from SCAD.
REQ-008 ARMM_SEL  in  1  ARMM source: 0 MAGIC/VMA section, 1 SCAD/zero.
REQ-009 MAGIC  in  9  CRAM magic number field.
REQ-010 EDP_AR  in  36  AR from EDP.
REQ-011 VMA_section  in  5  current VMA section, bits 13:17.
REQ-012 SCD_SC  out  10  shift count register.
REQ-013 SCD_FE  out  10  floating exponent register.
REQ-014 SCD_SCAD  out  10  combinational SCAD result.
REQ-015 SCD_ARMMupper  out  9  to EDP ARL mux bits 0:8.
REQ-016 SCD_ARMMlower  out  5  to EDP ARL mux bits 13:17.
REQ-017 SCD_SCneg  out  1  SC[0] (SC negative).
REQ-018 SCD_SCge36  out  1  SC non-negative and >= 36 decimal.
REQ-019 SCD_loopDone  out  1  registered one-cycle pulse when counting SC passes 0 -> 1777 octal.

Function
REQ-020 All SCAD arithmetic SHALL be 10-bit two's complement, modulo 1024, with no carry out retained.
REQ-021 AR position SHALL be {4'b0, AR[0:5]}; AR size SHALL be {4'b0, AR[6:11]}.
REQ-022 AR exponent SHALL be {AR[0], AR[0], AR[1:8] XOR {8{AR[0]}}}.
REQ-023 MAGIC used as an operand SHALL be sign-extended to 10 bits: {MAGIC[0], MAGIC[0:8]}.
REQ-024 SCD_SCAD SHALL be purely combinational from the current selects, SC, FE, AR and MAGIC.
REQ-025 SC_SEL=01 SHALL load SCAD at the next edge; 11 SHALL load {AR[18], AR[27:35]}; 10 SHALL load SC-1.
REQ-026 FE_LOAD SHALL load SCAD into FE at the next edge, independent of SC_SEL.
REQ-027 When FE_LOAD and SC_SEL=01 are both asserted, SC and FE SHALL both receive the same SCAD value.
REQ-028 Count-down SHALL wrap from 0000 to 1777 octal.
REQ-029 SCD_loopDone SHALL assert for exactly the cycle after an edge where SC_SEL=10 and SC was 0000.
REQ-030 When SC_SEL is not 10, SCD_loopDone SHALL deassert on the next edge.
REQ-031 ARMM_SEL=0: upper=MAGIC, lower=VMA_section; ARMM_SEL=1: upper=SCAD[1:9], lower=5'b0.
REQ-032 ARMM outputs SHALL be combinational, so EDP can capture them in the same cycle.
REQ-033 SCD_SCneg and SCD_SCge36 SHALL be decoded from the registered SC only.

Reset
REQ-034 While eboxReset is high, SC, FE and SCD_loopDone SHALL be 0, without waiting for a clock edge.
REQ-035 Reset asserted mid-count SHALL abandon the loop; the first edge after release SHALL act on the selects as then presented.

Structure
REQ-036 SCAD_OP, SCADA_SEL, SCADB_SEL and SC_SEL encodings SHALL be enum typedefs in the shared CRAM definitions package.
REQ-037 The SCAD SHALL be a sub-module scad_alu (10-bit A, B, op in; result out); the registers stay in scd.

Verification
REQ-038 MAGIC=000, SCADA=MAGIC, SCAD_OP=A, SC_SEL=01; then SC_SEL=10 for 1 cycle -> SC=1777 octal, loopDone=1 for one cycle, SCneg=1.
REQ-039 FE=0200 octal, SCADA=FE, SCADB=MAGIC=0010 octal, SCAD_OP=A-B, FE_LOAD -> FE=0170 octal.
REQ-040 AR=400000_000000 octal (negative, exponent field 0) -> AR exponent on SCAD (op A) = 1777 octal.
REQ-041 SC=0044 octal -> SCge36=1; SC=0043 octal -> SCge36=0; SC=1777 octal -> SCge36=0, SCneg=1.
REQ-042 Load SC=0003, count down; assert eboxReset between edges after 2 counts -> SC=0 immediately, no loopDone pulse.
REQ-043 ARMM_SEL=1, SCAD=0125 octal -> ARMMupper=125 octal, ARMMlower=0; ARMM_SEL=0, MAGIC=377 octal, VMA_section=5'b10101 -> upper=377 octal, lower=5'b10101.
